guess_judge: RTL and testbench

- Scores a player's 4-digit guess against the 4-digit secret produced by the number-generation block, Bulls-and-Cows style.
- A = digits correct in value and position; B = digits correct in value but wrong position, with correct handling of repeated digits.
- Sequential scanner with a start/done handshake, plus a per-game attempt counter and win/lose flags.
- Sits between the secret-generation stage and the display/control FSM.

---
 rtl/guess_judge_pkg.sv | 8 +
 rtl/guess_judge_digit_sel.sv | 10 +
 rtl/guess_judge.sv | 127 ++++++++++++
 tb/tb_guess_judge.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/guess_judge_pkg.sv
// guess_judge_pkg: shared state encoding and widths for the guess judge
package guess_judge_pkg;
  localparam int DIGIT_W = 4;
  localparam int NUM_DIGITS = 4;
  localparam int CNT_W = 3;
  localparam int TRY_W = 4;
  typedef enum logic [1:0] {IDLE, EXACT, CROSS, DONE} state_e;
endpackage

// File: rtl/guess_judge_digit_sel.sv
// guess_judge_digit_sel: picks one 4-bit digit out of a packed 4-digit word
module guess_judge_digit_sel
  import guess_judge_pkg::*;
(
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_i,
  input  logic [1:0]                    idx_i,
  output logic [DIGIT_W-1:0]            digit_o
);
  assign digit_o = digits_i[idx_i*DIGIT_W +: DIGIT_W];
endmodule

// File: rtl/guess_judge.sv
// guess_judge: sequential Bulls-and-Cows scorer with attempt counter and win/lose flags
module guess_judge
  import guess_judge_pkg::*;
#(
  parameter int MAX_TRIES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] s3,
  input  logic [DIGIT_W-1:0] s2,
  input  logic [DIGIT_W-1:0] s1,
  input  logic [DIGIT_W-1:0] s0,
  input  logic [DIGIT_W-1:0] g3,
  input  logic [DIGIT_W-1:0] g2,
  input  logic [DIGIT_W-1:0] g1,
  input  logic [DIGIT_W-1:0] g0,
  input  logic               start,
  input  logic               new_game,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   a_cnt,
  output logic [CNT_W-1:0]   b_cnt,
  output logic [TRY_W-1:0]   tries,
  output logic               win,
  output logic               lose,
  output logic               game_over
);
  localparam logic [TRY_W-1:0] MAX_T = TRY_W'(MAX_TRIES);
  state_e state_q;
  logic [NUM_DIGITS*DIGIT_W-1:0] sec_q, gue_q;
  logic [3:0] idx_q, smatch_q, gmatch_q;
  logic [CNT_W-1:0] a_q, b_q;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic busy_q, done_q, win_q, lose_q;
  logic [1:0] si, gi;
  logic [DIGIT_W-1:0] sd, gd;
  logic eq, cross_hit;
  // EXACT walks position k on both words; CROSS walks guess j (outer) and secret i (inner)
  assign si = idx_q[1:0];
  assign gi = state_q == CROSS ? idx_q[3:2] : idx_q[1:0];
  guess_judge_digit_sel u_sec_sel (.digits_i(sec_q), .idx_i(si), .digit_o(sd));
  guess_judge_digit_sel u_gue_sel (.digits_i(gue_q), .idx_i(gi), .digit_o(gd));
  assign eq = sd == gd;
  assign cross_hit = eq && !gmatch_q[gi] && !smatch_q[si];
  assign tries_d = tries_q == MAX_T ? tries_q : tries_q + TRY_W'(1);
  // Judge FSM: latch, exact scan, cross scan, then report and update game flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sec_q    <= '0;
      gue_q    <= '0;
      idx_q    <= '0;
      smatch_q <= '0;
      gmatch_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      tries_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else if (new_game) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      smatch_q <= '0;
      gmatch_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      tries_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start && !(win_q || lose_q)) begin
            sec_q    <= {s3, s2, s1, s0};
            gue_q    <= {g3, g2, g1, g0};
            idx_q    <= '0;
            smatch_q <= '0;
            gmatch_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            busy_q   <= 1'b1;
            state_q  <= EXACT;
          end
        end
        EXACT: begin
          if (eq) begin
            a_q          <= a_q + CNT_W'(1);
            smatch_q[si] <= 1'b1;
            gmatch_q[si] <= 1'b1;
          end
          idx_q   <= idx_q == 4'd3 ? '0 : idx_q + 4'd1;
          state_q <= idx_q == 4'd3 ? CROSS : EXACT;
        end
        CROSS: begin
          if (cross_hit) begin
            b_q          <= b_q + CNT_W'(1);
            smatch_q[si] <= 1'b1;
            gmatch_q[gi] <= 1'b1;
          end
          idx_q   <= idx_q + 4'd1;
          state_q <= idx_q == 4'd15 ? DONE : CROSS;
        end
        default: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          tries_q <= tries_d;
          if (a_q == CNT_W'(4)) win_q <= 1'b1;
          else if (tries_q + TRY_W'(1) == MAX_T) lose_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign a_cnt     = a_q;
  assign b_cnt     = b_q;
  assign tries     = tries_q;
  assign win       = win_q;
  assign lose      = lose_q;
  assign game_over = win_q | lose_q;
endmodule

// File: tb/tb_guess_judge.sv
// tb_guess_judge: directed vector table plus multi-cycle sequences for guess_judge
module tb_guess_judge;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, new_game = 1'b0;
  logic [3:0] s3 = '0, s2 = '0, s1 = '0, s0 = '0, g3 = '0, g2 = '0, g1 = '0, g0 = '0;
  logic busy, done, win, lose, game_over;
  logic [2:0] a_cnt, b_cnt;
  logic [3:0] tries;
  int errors = 0, checks = 0;
  typedef struct {
    logic [15:0] sv;
    logic [15:0] gv;
    int a;
    int b;
  } vec_t;
  vec_t vecs [10];
  guess_judge #(.MAX_TRIES(8)) dut (
    .clk(clk), .rst(rst), .s3(s3), .s2(s2), .s1(s1), .s0(s0),
    .g3(g3), .g2(g2), .g1(g1), .g0(g0), .start(start), .new_game(new_game),
    .busy(busy), .done(done), .a_cnt(a_cnt), .b_cnt(b_cnt), .tries(tries),
    .win(win), .lose(lose), .game_over(game_over)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic put(input logic [15:0] sv, input logic [15:0] gv);
    {s3, s2, s1, s0} = sv;
    {g3, g2, g1, g0} = gv;
  endtask
  task automatic do_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask
  task automatic judge(input logic [15:0] sv, input logic [15:0] gv,
                       input int chg_at, input logic [3:0] chg_g0, output int lat);
    put(sv, gv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == chg_at) g0 = chg_g0;
    end
  endtask
  initial begin
    int lat;
    bit seen;
    vecs[0] = '{16'h1234, 16'h1234, 4, 0};
    vecs[1] = '{16'h1234, 16'h4321, 0, 4};
    vecs[2] = '{16'h1123, 16'h2111, 1, 2};
    vecs[3] = '{16'h1123, 16'h1111, 2, 0};
    vecs[4] = '{16'h1234, 16'h5678, 0, 0};
    vecs[5] = '{16'h1234, 16'h1243, 2, 2};
    vecs[6] = '{16'hAAAA, 16'hA0A0, 2, 0};
    vecs[7] = '{16'h0F0F, 16'hF0F0, 0, 4};
    vecs[8] = '{16'h1122, 16'h2211, 0, 4};
    vecs[9] = '{16'h1112, 16'h2111, 2, 2};
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_a", a_cnt, 0);
    chk("rst_b", b_cnt, 0);
    chk("rst_tries", tries, 0);
    chk("rst_game_over", game_over, 0);
    rst = 1'b0;
    @(negedge clk);
    foreach (vecs[n]) begin
      do_new_game();
      judge(vecs[n].sv, vecs[n].gv, -1, 4'h0, lat);
      chk($sformatf("v%0d_latency", n), lat, 21);
      chk($sformatf("v%0d_a", n), a_cnt, vecs[n].a);
      chk($sformatf("v%0d_b", n), b_cnt, vecs[n].b);
      chk($sformatf("v%0d_win", n), win, vecs[n].a == 4 ? 1 : 0);
      chk($sformatf("v%0d_tries", n), tries, 1);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", n), done, 0);
    end
    do_new_game();
    judge(16'h1234, 16'h1234, -1, 4'h0, lat);
    chk("win_game_over", game_over, 1);
    chk("win_lose", lose, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("over_start_busy", busy, 0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("over_start_no_done", seen, 0);
    chk("over_start_tries", tries, 1);
    do_new_game();
    for (int t = 0; t < 8; t++) begin
      judge(16'h1234, 16'h0000, -1, 4'h0, lat);
      chk($sformatf("lose%0d_latency", t), lat, 21);
      chk($sformatf("lose%0d_a", t), a_cnt, 0);
      chk($sformatf("lose%0d_b", t), b_cnt, 0);
      chk($sformatf("lose%0d_lose", t), lose, t == 7 ? 1 : 0);
      chk($sformatf("lose%0d_tries", t), tries, t + 1);
      @(negedge clk);
    end
    chk("lose_win", win, 0);
    chk("lose_game_over", game_over, 1);
    do_new_game();
    chk("ng_tries", tries, 0);
    chk("ng_lose", lose, 0);
    judge(16'h1234, 16'h1243, -1, 4'h0, lat);
    chk("ng_latency", lat, 21);
    chk("ng_tries_after", tries, 1);
    @(negedge clk);
    put(16'h1234, 16'h5678);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_a", a_cnt, 0);
    chk("arst_tries", tries, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("arst_no_done", seen, 0);
    judge(16'h1234, 16'h1243, -1, 4'h0, lat);
    chk("ng2_prep_a", a_cnt, 2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    do_new_game();
    chk("abort_busy", busy, 0);
    chk("abort_a", a_cnt, 0);
    chk("abort_tries", tries, 0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    judge(16'h1234, 16'h1234, 8, 4'h9, lat);
    chk("latch_latency", lat, 21);
    chk("latch_a", a_cnt, 4);
    chk("latch_b", b_cnt, 0);
    chk("latch_win", win, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
